// File: rtl/id_stage_hazard.sv
// MIPS instruction-decode stage: register file with WB bypass, load-use/branch
// hazard detection, early branch/jump resolution and the registered ID/EX stage.
module id_stage_hazard #(
    parameter int DATA_W      = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int PC_W        = 32
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    input  logic [31:0]            i_instruction,
    input  logic [PC_W-1:0]        i_pcounter4,
    input  logic                   i_we_wb,
    input  logic [NB_REG_ADDR-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]      i_wr_data_WB,
    input  logic                   i_exmem_regWrite,
    input  logic [NB_REG_ADDR-1:0] i_exmem_wr_addr,
    input  logic                   i_stall,
    input  logic                   i_flush,
    output logic                   o_hazard_stall,
    output logic                   o_pc_src,
    output logic [PC_W-1:0]        o_pc_target,
    output logic                   o_valid,
    output logic [NB_REG_ADDR-1:0] o_rs,
    output logic [NB_REG_ADDR-1:0] o_rt,
    output logic [NB_REG_ADDR-1:0] o_rd,
    output logic [4:0]             o_shamt,
    output logic [5:0]             o_func,
    output logic [5:0]             o_opcode,
    output logic [DATA_W-1:0]      o_reg_DA,
    output logic [DATA_W-1:0]      o_reg_DB,
    output logic [DATA_W-1:0]      o_immediate,
    output logic                   o_regDst,
    output logic                   o_mem2Reg,
    output logic                   o_memRead,
    output logic                   o_memWrite,
    output logic                   o_regWrite,
    output logic [1:0]             o_aluSrc,
    output logic [1:0]             o_aluOp
);

    localparam int NUM_REGS = 2 ** NB_REG_ADDR;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [DATA_W-1:0] rf [NUM_REGS];

    logic [5:0]             opcode;
    logic [5:0]             func;
    logic [4:0]             shamt;
    logic [15:0]            imm16;
    logic [NB_REG_ADDR-1:0] rs;
    logic [NB_REG_ADDR-1:0] rt;
    logic [NB_REG_ADDR-1:0] rd;

    assign opcode = i_instruction[31:26];
    assign func   = i_instruction[5:0];
    assign shamt  = i_instruction[10:6];
    assign imm16  = i_instruction[15:0];
    assign rs     = NB_REG_ADDR'(i_instruction[25:21]);
    assign rt     = NB_REG_ADDR'(i_instruction[20:16]);
    assign rd     = NB_REG_ADDR'(i_instruction[15:11]);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (i_we_wb && i_wr_addr != '0) begin
            rf[i_wr_addr] <= i_wr_data_WB;
        end
    end

    // Reads see a same-cycle WB write so the producer needs no extra stall.
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    always_comb begin
        rs_data = rf[rs];
        rt_data = rf[rt];
        if (i_we_wb && i_wr_addr == rs) rs_data = i_wr_data_WB;
        if (i_we_wb && i_wr_addr == rt) rt_data = i_wr_data_WB;
        if (rs == '0) rs_data = '0;
        if (rt == '0) rt_data = '0;
    end

    logic       dec_reg_dst;
    logic       dec_mem2reg;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_reg_write;
    logic [1:0] dec_alu_src;
    logic [1:0] dec_alu_op;
    logic       dec_zext;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       uses_rt;

    always_comb begin
        dec_reg_dst   = 1'b0;
        dec_mem2reg   = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_reg_write = 1'b0;
        dec_alu_src   = 2'b00;
        dec_alu_op    = 2'b00;
        dec_zext      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_dst   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_op    = 2'b10;
                if (func == 6'b000000 || func == 6'b000010 || func == 6'b000011) begin
                    dec_alu_src = 2'b11;
                end
            end
            OP_ADDI, OP_SLTI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 2'b01;
                dec_alu_op    = (opcode == OP_SLTI) ? 2'b11 : 2'b00;
            end
            OP_ANDI, OP_ORI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 2'b10;
                dec_alu_op    = 2'b11;
                dec_zext      = 1'b1;
            end
            OP_LW: begin
                dec_mem_read  = 1'b1;
                dec_mem2reg   = 1'b1;
                dec_reg_write = 1'b1;
                dec_alu_src   = 2'b01;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 2'b01;
            end
            OP_BEQ, OP_BNE: begin
                dec_alu_op = 2'b01;
            end
            default: begin
            end
        endcase
    end

    assign is_beq  = (opcode == OP_BEQ);
    assign is_bne  = (opcode == OP_BNE);
    assign is_j    = (opcode == OP_J);
    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || is_beq || is_bne;

    // Hazards are judged against the instruction currently held in ID/EX.
    logic [NB_REG_ADDR-1:0] idex_dest;
    logic                   idex_dest_live;
    logic                   load_use;
    logic                   rs_busy;
    logic                   rt_busy;
    logic                   branch_dep;

    assign idex_dest      = o_regDst ? o_rd : o_rt;
    assign idex_dest_live = o_valid && o_regWrite && (idex_dest != '0);
    assign load_use       = o_memRead && idex_dest_live &&
                            ((idex_dest == rs) || (uses_rt && idex_dest == rt));
    assign rs_busy        = (rs != '0) && ((idex_dest_live && rs == idex_dest) ||
                                           (i_exmem_regWrite && rs == i_exmem_wr_addr));
    assign rt_busy        = (rt != '0) && ((idex_dest_live && rt == idex_dest) ||
                                           (i_exmem_regWrite && rt == i_exmem_wr_addr));
    assign branch_dep     = (is_beq || is_bne) && (rs_busy || rt_busy);
    assign o_hazard_stall = i_valid && (load_use || branch_dep);

    logic [PC_W-1:0] br_offset;
    logic [PC_W-1:0] j_target;
    logic            operands_eq;

    assign br_offset   = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
    assign j_target    = {i_pcounter4[PC_W-1:28], i_instruction[25:0], 2'b00};
    assign operands_eq = (rs_data == rt_data);
    assign o_pc_target = is_j ? j_target : (i_pcounter4 + br_offset);
    assign o_pc_src    = i_valid && !o_hazard_stall && !i_stall &&
                         (is_j || (is_beq && operands_eq) || (is_bne && !operands_eq));

    // An empty IF/ID slot enters ID/EX as a bubble, same as flush or hazard.
    logic bubble;
    logic load_ctl;

    assign bubble   = i_flush || o_hazard_stall;
    assign load_ctl = i_valid && !bubble;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid     <= 1'b0;
            o_rs        <= '0;
            o_rt        <= '0;
            o_rd        <= '0;
            o_shamt     <= '0;
            o_func      <= '0;
            o_opcode    <= '0;
            o_reg_DA    <= '0;
            o_reg_DB    <= '0;
            o_immediate <= '0;
            o_regDst    <= 1'b0;
            o_mem2Reg   <= 1'b0;
            o_memRead   <= 1'b0;
            o_memWrite  <= 1'b0;
            o_regWrite  <= 1'b0;
            o_aluSrc    <= 2'b00;
            o_aluOp     <= 2'b00;
        end else if (!i_stall) begin
            o_valid     <= i_valid && !bubble;
            o_rs        <= bubble ? '0 : rs;
            o_rt        <= bubble ? '0 : rt;
            o_rd        <= bubble ? '0 : rd;
            o_shamt     <= bubble ? '0 : shamt;
            o_func      <= bubble ? '0 : func;
            o_opcode    <= bubble ? '0 : opcode;
            o_reg_DA    <= bubble ? '0 : rs_data;
            o_reg_DB    <= bubble ? '0 : rt_data;
            o_immediate <= bubble ? '0 :
                           (dec_zext ? {{(DATA_W-16){1'b0}}, imm16}
                                     : {{(DATA_W-16){imm16[15]}}, imm16});
            o_regDst    <= load_ctl && dec_reg_dst;
            o_mem2Reg   <= load_ctl && dec_mem2reg;
            o_memRead   <= load_ctl && dec_mem_read;
            o_memWrite  <= load_ctl && dec_mem_write;
            o_regWrite  <= load_ctl && dec_reg_write;
            o_aluSrc    <= load_ctl ? dec_alu_src : 2'b00;
            o_aluOp     <= load_ctl ? dec_alu_op : 2'b00;
        end
    end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Table-driven bench for id_stage_hazard: combinational outputs checked before
// each edge, registered ID/EX outputs checked through a scoreboard queue after it.
module tb_id_stage_hazard;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_instruction;
    logic [31:0] i_pcounter4;
    logic        i_we_wb;
    logic [4:0]  i_wr_addr;
    logic [31:0] i_wr_data_WB;
    logic        i_exmem_regWrite;
    logic [4:0]  i_exmem_wr_addr;
    logic        i_stall;
    logic        i_flush;
    logic        o_hazard_stall;
    logic        o_pc_src;
    logic [31:0] o_pc_target;
    logic        o_valid;
    logic [4:0]  o_rs;
    logic [4:0]  o_rt;
    logic [4:0]  o_rd;
    logic [4:0]  o_shamt;
    logic [5:0]  o_func;
    logic [5:0]  o_opcode;
    logic [31:0] o_reg_DA;
    logic [31:0] o_reg_DB;
    logic [31:0] o_immediate;
    logic        o_regDst;
    logic        o_mem2Reg;
    logic        o_memRead;
    logic        o_memWrite;
    logic        o_regWrite;
    logic [1:0]  o_aluSrc;
    logic [1:0]  o_aluOp;

    always #5 clk = ~clk;

    id_stage_hazard dut (
        .clk              (clk),
        .i_rst_n          (i_rst_n),
        .i_valid          (i_valid),
        .i_instruction    (i_instruction),
        .i_pcounter4      (i_pcounter4),
        .i_we_wb          (i_we_wb),
        .i_wr_addr        (i_wr_addr),
        .i_wr_data_WB     (i_wr_data_WB),
        .i_exmem_regWrite (i_exmem_regWrite),
        .i_exmem_wr_addr  (i_exmem_wr_addr),
        .i_stall          (i_stall),
        .i_flush          (i_flush),
        .o_hazard_stall   (o_hazard_stall),
        .o_pc_src         (o_pc_src),
        .o_pc_target      (o_pc_target),
        .o_valid          (o_valid),
        .o_rs             (o_rs),
        .o_rt             (o_rt),
        .o_rd             (o_rd),
        .o_shamt          (o_shamt),
        .o_func           (o_func),
        .o_opcode         (o_opcode),
        .o_reg_DA         (o_reg_DA),
        .o_reg_DB         (o_reg_DB),
        .o_immediate      (o_immediate),
        .o_regDst         (o_regDst),
        .o_mem2Reg        (o_mem2Reg),
        .o_memRead        (o_memRead),
        .o_memWrite       (o_memWrite),
        .o_regWrite       (o_regWrite),
        .o_aluSrc         (o_aluSrc),
        .o_aluOp          (o_aluOp)
    );

    // Control bundle {regDst, mem2Reg, memRead, memWrite, regWrite, aluSrc, aluOp}
    localparam logic [8:0] C_NONE = 9'b000000000;
    localparam logic [8:0] C_R    = 9'b100010010;
    localparam logic [8:0] C_RSH  = 9'b100011110;
    localparam logic [8:0] C_ADDI = 9'b000010100;
    localparam logic [8:0] C_ANDI = 9'b000011011;
    localparam logic [8:0] C_LW   = 9'b011010100;
    localparam logic [8:0] C_SW   = 9'b000100100;
    localparam logic [8:0] C_BR   = 9'b000000001;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exw;
        logic [4:0]  exaddr;
        logic        stall;
        logic        flush;
        logic        e_haz;
        logic        e_src;
        logic        chk_tgt;
        logic [31:0] e_tgt;
        logic        e_valid;
        logic [4:0]  e_rd;
        logic [31:0] e_da;
        logic [31:0] e_db;
        logic [31:0] e_imm;
        logic [8:0]  e_ctl;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];
    vec_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int txn    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(
        input string nm, input logic valid, input logic [31:0] instr, input logic [31:0] pc4,
        input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
        input logic exw, input logic [4:0] exaddr, input logic stall, input logic flush,
        input logic e_haz, input logic e_src, input logic chk_tgt, input logic [31:0] e_tgt,
        input logic e_valid, input logic [4:0] e_rd, input logic [31:0] e_da,
        input logic [31:0] e_db, input logic [31:0] e_imm, input logic [8:0] e_ctl);
        vec_t v;
        v.name = nm; v.valid = valid; v.instr = instr; v.pc4 = pc4;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.exw = exw; v.exaddr = exaddr;
        v.stall = stall; v.flush = flush; v.e_haz = e_haz; v.e_src = e_src;
        v.chk_tgt = chk_tgt; v.e_tgt = e_tgt; v.e_valid = e_valid; v.e_rd = e_rd;
        v.e_da = e_da; v.e_db = e_db; v.e_imm = e_imm; v.e_ctl = e_ctl;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge clk);
        i_valid          = v.valid;
        i_instruction    = v.instr;
        i_pcounter4      = v.pc4;
        i_we_wb          = v.we;
        i_wr_addr        = v.waddr;
        i_wr_data_WB     = v.wdata;
        i_exmem_regWrite = v.exw;
        i_exmem_wr_addr  = v.exaddr;
        i_stall          = v.stall;
        i_flush          = v.flush;
        #1;
        chk({v.name, ".hazard"}, {31'd0, o_hazard_stall}, {31'd0, v.e_haz});
        chk({v.name, ".pc_src"}, {31'd0, o_pc_src}, {31'd0, v.e_src});
        if (v.chk_tgt) chk({v.name, ".target"}, o_pc_target, v.e_tgt);
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({v.name, ".scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({e.name, ".valid"}, {31'd0, o_valid}, {31'd0, e.e_valid});
            chk({e.name, ".ctl"},
                {23'd0, o_regDst, o_mem2Reg, o_memRead, o_memWrite, o_regWrite, o_aluSrc, o_aluOp},
                {23'd0, e.e_ctl});
            if (e.e_valid) begin
                chk({e.name, ".rd"}, {27'd0, o_rd}, {27'd0, e.e_rd});
                chk({e.name, ".DA"}, o_reg_DA, e.e_da);
                chk({e.name, ".DB"}, o_reg_DB, e.e_db);
                chk({e.name, ".imm"}, o_immediate, e.e_imm);
            end
        end
        $display("txn %0d %s haz=%0b src=%0b tgt=%h valid=%0b DA=%h DB=%h imm=%h",
                 txn, v.name, v.e_haz, v.e_src, o_pc_target, o_valid, o_reg_DA, o_reg_DB, o_immediate);
        txn++;
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_instruction = '0; i_pcounter4 = '0;
        i_we_wb = 1'b0; i_wr_addr = '0; i_wr_data_WB = '0; i_exmem_regWrite = 1'b0;
        i_exmem_wr_addr = '0; i_stall = 1'b0; i_flush = 1'b0;

        //            name       vld instr         pc4           we wa  wdata        exw exa st fl  haz src ct tgt           ev rd  DA           DB           imm          ctl
        vecs_a.push_back(mk("wb_r1",   0, 32'h0,        32'h0,        1, 1,  32'd5,        0, 0, 0, 0,  0, 0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        32'h0,        C_NONE));
        vecs_a.push_back(mk("wb_r2",   0, 32'h0,        32'h0,        1, 2,  32'd7,        0, 0, 0, 0,  0, 0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        32'h0,        C_NONE));
        vecs_a.push_back(mk("add",     1, 32'h00221820, 32'h4,        0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 3,  32'd5,        32'd7,        32'h1820,     C_R));
        vecs_a.push_back(mk("addi_byp",1, 32'h2085FFFC, 32'h8,        1, 4,  32'hAA,       0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 31, 32'hAA,       32'h0,        32'hFFFFFFFC, C_ADDI));
        vecs_a.push_back(mk("r0_wr",   1, 32'h00011820, 32'hC,        1, 0,  32'h55,       0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 3,  32'h0,        32'd5,        32'h1820,     C_R));
        vecs_a.push_back(mk("lw",      1, 32'h8C220000, 32'h10,       0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 0,  32'd5,        32'd7,        32'h0,        C_LW));
        vecs_a.push_back(mk("ld_use",  1, 32'h00411820, 32'h14,       0, 0,  32'h0,        0, 0, 0, 0,  1, 0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        32'h0,        C_NONE));
        vecs_a.push_back(mk("ld_issue",1, 32'h00411820, 32'h14,       0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 3,  32'd7,        32'd5,        32'h1820,     C_R));
        vecs_a.push_back(mk("beq",     1, 32'h10210003, 32'h100,      0, 0,  32'h0,        0, 0, 0, 0,  0, 1, 1, 32'h10C,      1, 0,  32'd5,        32'd5,        32'h3,        C_BR));
        vecs_a.push_back(mk("bne",     1, 32'h14210003, 32'h100,      0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 1, 32'h10C,      1, 0,  32'd5,        32'd5,        32'h3,        C_BR));
        vecs_a.push_back(mk("jump",    1, 32'h08000010, 32'h10000004, 0, 0,  32'h0,        0, 0, 0, 0,  0, 1, 1, 32'h10000040, 1, 0,  32'h0,        32'h0,        32'h10,       C_NONE));
        vecs_a.push_back(mk("stall",   1, 32'h08000010, 32'h10000004, 0, 0,  32'h0,        0, 0, 1, 0,  0, 0, 1, 32'h10000040, 1, 0,  32'h0,        32'h0,        32'h10,       C_NONE));
        vecs_a.push_back(mk("flush",   1, 32'h00221820, 32'h20,       0, 0,  32'h0,        0, 0, 0, 1,  0, 0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        32'h0,        C_NONE));
        vecs_a.push_back(mk("br_exmem",1, 32'h10C00001, 32'h200,      0, 0,  32'h0,        1, 6, 0, 0,  1, 0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        32'h0,        C_NONE));
        vecs_a.push_back(mk("br_clear",1, 32'h10C00001, 32'h200,      0, 0,  32'h0,        0, 0, 0, 0,  0, 1, 1, 32'h204,      1, 0,  32'h0,        32'h0,        32'h1,        C_BR));
        vecs_a.push_back(mk("andi",    1, 32'h30278000, 32'h204,      0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 16, 32'd5,        32'h0,        32'h8000,     C_ANDI));
        vecs_a.push_back(mk("unknown", 1, 32'hFC000000, 32'h208,      0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 0,  32'h0,        32'h0,        32'h0,        C_NONE));
        vecs_a.push_back(mk("sll",     1, 32'h00024100, 32'h20C,      0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 8,  32'h0,        32'd7,        32'h4100,     C_RSH));

        vecs_b.push_back(mk("rst_add", 1, 32'h00221820, 32'h4,        0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 3,  32'h0,        32'h0,        32'h1820,     C_R));
        vecs_b.push_back(mk("lw_r9",   1, 32'h8C090000, 32'h8,        0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 0,  32'h0,        32'h0,        32'h0,        C_LW));
        vecs_b.push_back(mk("sw_use",  1, 32'hAC090004, 32'hC,        0, 0,  32'h0,        0, 0, 0, 0,  1, 0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        32'h0,        C_NONE));
        vecs_b.push_back(mk("sw_issue",1, 32'hAC090004, 32'hC,        0, 0,  32'h0,        0, 0, 0, 0,  0, 0, 0, 32'h0,        1, 0,  32'h0,        32'h0,        32'h4,        C_SW));

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset.valid", {31'd0, o_valid}, 32'd0);
        chk("reset.regWrite", {31'd0, o_regWrite}, 32'd0);
        chk("reset.DA", o_reg_DA, 32'd0);
        chk("reset.hazard", {31'd0, o_hazard_stall}, 32'd0);
        chk("reset.pc_src", {31'd0, o_pc_src}, 32'd0);
        chk("reset.target", o_pc_target, 32'd0);
        i_rst_n = 1'b1;

        foreach (vecs_a[i]) run_vec(vecs_a[i]);

        // Mid-operation reset: ID/EX clears without a clock edge, file is wiped.
        @(negedge clk);
        i_valid = 1'b0; i_we_wb = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_exmem_regWrite = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst.valid", {31'd0, o_valid}, 32'd0);
        chk("midrst.regDst", {31'd0, o_regDst}, 32'd0);
        chk("midrst.DB", o_reg_DB, 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;

        foreach (vecs_b[i]) run_vec(vecs_b[i]);

        chk("scoreboard.empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/id_stage_hazard.md
Name: id_stage_hazard

Overview:
Next-generation MIPS instruction-decode stage with a parametrised register file, write-back bypass, an in-stage load-use/branch hazard unit, early branch/jump resolution and a registered ID/EX pipeline register with stall and flush. It sits between the IF/ID register and the execute stage. It drives PC-select/target back to fetch and a hazard stall to hold IF.

Parameters:
DATA_W, 32, register/datapath width (>=32); immediates sign/zero-extended to DATA_W
NB_REG_ADDR, 5, register address width; register count = 2**NB_REG_ADDR
PC_W, 32, program-counter width

Ports:
clk  in  1  clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  IF/ID holds a real instruction
i_instruction  in  32  instruction word
i_pcounter4  in  PC_W  PC+4 of instruction
i_we_wb  in  1  WB register write enable
i_wr_addr  in  NB_REG_ADDR  WB write address
i_wr_data_WB  in  DATA_W  WB write data
i_exmem_regWrite  in  1  EX/MEM instruction writes a register
i_exmem_wr_addr  in  NB_REG_ADDR  EX/MEM destination
i_stall  in  1  external freeze (debug halt)
i_flush  in  1  insert bubble into ID/EX
o_hazard_stall  out  1  combinational: hold PC and IF/ID
o_pc_src  out  1  combinational: take o_pc_target
o_pc_target  out  PC_W  combinational branch/jump target
o_valid, o_rs, o_rt, o_rd, o_shamt, o_func, o_opcode  out  1/NB_REG_ADDR x3/5/6/6  registered ID/EX fields
o_reg_DA, o_reg_DB, o_immediate  out  DATA_W  registered operands/extended immediate
o_regDst, o_mem2Reg, o_memRead, o_memWrite, o_regWrite  out  1  registered controls
o_aluSrc, o_aluOp  out  2  registered ALU controls

Behaviour:
- Reset (async, i_rst_n=0): all registers in file = 0; every registered output = 0. Combinational outputs then follow from zero state.
- Register file: write on rising edge when i_we_wb && i_wr_addr!=0; reg 0 reads 0 always. Read bypass: same-cycle WB write to a read address returns i_wr_data_WB.
- Decode: R 000000 (regDst=1, regWrite=1, aluOp=10, aluSrc=11 if func in {000000,000010,000011}, else 00); ADDI 001000 / SLTI 001010 (aluOp=00/11, aluSrc=01 sign-ext, regWrite=1); ANDI 001100 / ORI 001101 (aluOp=11, aluSrc=10 zero-ext, regWrite=1); LW 100011 (memRead, mem2Reg, regWrite, aluSrc=01, aluOp=00); SW 101011 (memWrite, aluSrc=01); BEQ 000100 / BNE 000101 (aluOp=01); J 000010. Unknown opcode: all controls 0, o_valid still follows i_valid.
- Destination of ID/EX entry = o_regDst ? o_rd : o_rt. It is valid for hazards only if o_valid && o_regWrite && dest!=0.
- Hazard (o_hazard_stall=1) when i_valid and either:
  - ID/EX is a load (o_memRead) whose dest matches rs, or rt for R/SW/BEQ/BNE; or
  - current is BEQ/BNE and rs or rt (nonzero) matches the ID/EX dest or i_exmem_wr_addr with i_exmem_regWrite.
- o_pc_src=1 when i_valid, !o_hazard_stall, !i_stall and: J; BEQ with DA==DB; or BNE with DA!=DB.
- Targets: branch = i_pcounter4 + (sext(imm)<<2), mod 2**PC_W; J = {i_pcounter4[PC_W-1:28], instr[25:0], 2'b00}.
- ID/EX update priority, per edge:
  - i_stall: hold all outputs.
  - else i_flush: bubble (o_valid and all controls 0; data fields don't-care, drive 0).
  - else o_hazard_stall: bubble.
  - else: load decoded instruction, 1-cycle latency.
- Branch/J itself enters ID/EX with regWrite/mem controls 0. Fetch handles flushing of the slot after a taken branch.
- Mid-operation reset clears the pipeline register and file immediately.

Test Plan:
- Reset, WB write r1=5, r2=7, then ADD $3,$1,$2 (0x00221820) -> next edge o_reg_DA=5, o_reg_DB=7, o_rd=3, o_regDst=1, o_aluOp=10, o_valid=1.
- WB writes r4=0xAA in the same cycle ADDI $5,$4,-4 decodes -> o_reg_DA=0xAA (bypass), o_immediate=0xFFFFFFFC, aluSrc=01; write to r0 ignored, r0 reads 0.
- LW $2,0($1) then ADD $3,$2,$1 -> o_hazard_stall=1 for one cycle, ID/EX holds bubble (o_valid=0, regWrite=0), ADD issues next cycle.
- BEQ $1,$1,+3 at pc4=0x100 with no in-flight producer -> o_pc_src=1, o_pc_target=0x10C. BNE same operands -> o_pc_src=0.
- J 16 (0x08000010) at pc4=0x1000_0004 -> o_pc_target=0x1000_0040. i_stall=1 freezes outputs; i_flush=1 yields bubble.
- EX/MEM writes r6 (i_exmem_regWrite=1), BEQ $6,$0 -> stall asserted, o_pc_src=0 until producer clears.
